spectral_flux: RTL and testbench
================================

Name: spectral_flux

Overview:
Computes per-frame spectral flux from a stream of squared FFT bin magnitudes. Each bin is compared with the same bin of the previous frame, and positive differences are summed into a total flux and three sub-band fluxes. A simple onset/beat flag is derived from a running average of the flux. The block sits between the FFT magnitude stage and the beat/tempo logic.

Parameters:
- W, 16, width of mag_sq and of each stored bin.
- N, 8, bins per frame; power of two, >= 4.
- MAX_FLUX_LENGTH, 32, width of all flux outputs and accumulators; must be >= W + log2(N).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- mag_valid  in  1  mag_sq carries a valid bin this cycle
- mag_sq  in  W  squared magnitude of the current bin (unsigned)
- flux_value  out  MAX_FLUX_LENGTH  total flux of the last completed frame (registered)
- flux_valid  out  1  1-cycle pulse: flux_value and band outputs updated
- beat_valid  out  1  1-cycle pulse coincident with flux_valid when an onset is detected
- frame_done  out  1  1-cycle pulse, same cycle as flux_valid
- flux_low  out  MAX_FLUX_LENGTH  flux of bins [0, N/4)
- flux_mid  out  MAX_FLUX_LENGTH  flux of bins [N/4, N/2)
- flux_high  out  MAX_FLUX_LENGTH  flux of bins [N/2, N)
- flux_accum  out  MAX_FLUX_LENGTH  live running total of the current frame (debug)

Behaviour:
- One clock (clk); reset is synchronous and active-high.
- Reset clears the following to 0: all outputs, bin counter, accumulators, running average, and the N-entry previous-frame memory.
- Bin index counter:
  - Advances only on cycles with mag_valid = 1.
  - Idle cycles inside a frame are allowed and are ignored.
  - Counter wraps N-1 -> 0.
- Per accepted bin i:
  - d = mag_sq - prev[i] if mag_sq > prev[i], else 0 (half-wave rectified, unsigned).
  - prev[i] <= mag_sq in the same cycle.
  - d is added to the total accumulator and to the band accumulator selected by i.
  - All accumulators saturate at 2^MAX_FLUX_LENGTH - 1.
- flux_accum shows the total accumulator; it updates the cycle after each accepted bin.
- Frame end (bin N-1 accepted in cycle T), in cycle T+1:
  - flux_value, flux_low, flux_mid and flux_high are loaded with the final sums, including bin N-1.
  - flux_valid and frame_done pulse high for exactly one cycle.
  - The internal accumulators restart at 0 for the next frame.
  - A bin accepted in cycle T+1 belongs to the next frame and must not be lost; back-to-back frames are legal.
- Flux outputs hold their value until the next frame end.
- Beat detection, evaluated at frame end with F = new flux:
  - beat_valid = (F != 0) && (F > avg + (avg >> 1)), using the avg value from before this frame's update.
  - Then avg <= avg - (avg >> 3) + (F >> 3), with MAX_FLUX_LENGTH-bit unsigned arithmetic.
  - beat_valid is only ever high in the flux_valid cycle.
- First frame after reset: prev is all 0, so flux equals the sum of the magnitudes.
- Reset mid-frame discards the partial frame; no flux_valid is produced for it.
- An all-equal or decreasing frame gives flux = 0, flux_valid still pulses, and beat_valid = 0.

Decomposition:
- Package spectral_flux_pkg holds:
  - default constants W, N, MAX_FLUX_LENGTH;
  - band boundaries LOW_END = N/4 and MID_END = N/2;
  - AVG_SHIFT = 3;
  - typedef flux_t for a MAX_FLUX_LENGTH-bit unsigned value;
  - a saturating-add function.
- One natural sub-module, flux_beat_detector: holds the running average and the threshold compare, with flux_t input, a strobe, and beat_valid output.

Test Plan:
- Reset, then frame of 8 x 200 -> flux_value=1600, flux_low=400, flux_mid=400, flux_high=800, flux_valid, frame_done and beat_valid pulse once, the cycle after the 8th bin.
- Next frame, ramp 100+20*i (100..240) -> flux_value=60, low=0, mid=0, high=60, beat_valid=0 (avg=200, threshold 300).
- Next frame, bins 100,700,1400,100,700,1400,100,700 -> flux_value=4020, low=580, mid=1260, high=2180, beat_valid=1 (avg=182, threshold 273).
- Repeat an identical frame twice -> second flux_value=0, flux_valid pulses, beat_valid=0.
- Frame with mag_valid gaps inserted between bins -> same results as the gapless frame; flux_accum steps by each d.
- Assert reset after 4 bins, then send a full frame of 8 x 200 -> no pulse for the partial frame; flux_value=1600 (prev memory cleared).

Source files
------------

// File: rtl/spectral_flux_pkg.sv
// spectral_flux_pkg: shared constants, flux type and saturating add for the spectral flux block.
package spectral_flux_pkg;
   localparam int W               = 16;
   localparam int N               = 8;
   localparam int MAX_FLUX_LENGTH = 32;
   localparam int LOW_END         = N / 4;
   localparam int MID_END         = N / 2;
   localparam int AVG_SHIFT       = 3;

   typedef logic [MAX_FLUX_LENGTH-1:0] flux_t;

   function automatic flux_t sat_add(flux_t a, flux_t b);
      logic [MAX_FLUX_LENGTH:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[MAX_FLUX_LENGTH] ? '1 : s[MAX_FLUX_LENGTH-1:0];
   endfunction
endpackage

// File: rtl/spectral_flux_if.sv
// spectral_flux_if: magnitude stream in, per-frame flux results out.
//   master: drives mag_valid/mag_sq, observes results (testbench / FFT side)
//   slave : consumes magnitudes, drives flux_*, beat_valid, frame_done (spectral_flux)
interface spectral_flux_if
   import spectral_flux_pkg::*;
#(
   parameter int W = spectral_flux_pkg::W
);
   logic         mag_valid;
   logic [W-1:0] mag_sq;
   flux_t        flux_value;
   flux_t        flux_low;
   flux_t        flux_mid;
   flux_t        flux_high;
   flux_t        flux_accum;
   logic         flux_valid;
   logic         beat_valid;
   logic         frame_done;

   modport master (
      output mag_valid, mag_sq,
      input  flux_value, flux_low, flux_mid, flux_high, flux_accum,
             flux_valid, beat_valid, frame_done
   );

   modport slave (
      input  mag_valid, mag_sq,
      output flux_value, flux_low, flux_mid, flux_high, flux_accum,
             flux_valid, beat_valid, frame_done
   );
endinterface

// File: rtl/spectral_flux_beat_detector.sv
// flux_beat_detector: running flux average and onset threshold compare.
//   clk, reset : clock, synchronous active-high reset
//   flux_i     : flux of the frame just completed
//   strobe_i   : flux_i is valid (frame end)
//   beat_o     : registered onset flag, high the cycle after strobe_i
module flux_beat_detector
   import spectral_flux_pkg::*;
(
   input  logic  clk,
   input  logic  reset,
   input  flux_t flux_i,
   input  logic  strobe_i,
   output logic  beat_o
);
   flux_t                    avg_q, avg_d;
   logic                     beat_q, beat_d;
   logic [MAX_FLUX_LENGTH:0] thr;

   // Threshold is 1.5 * avg, kept one bit wider so it cannot wrap.
   always_comb begin
      thr    = {1'b0, avg_q} + {1'b0, avg_q >> 1};
      beat_d = strobe_i && (flux_i != '0) && ({1'b0, flux_i} > thr);
      avg_d  = strobe_i ? avg_q - (avg_q >> AVG_SHIFT) + (flux_i >> AVG_SHIFT) : avg_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         avg_q  <= '0;
         beat_q <= 1'b0;
      end else begin
         avg_q  <= avg_d;
         beat_q <= beat_d;
      end
   end

   assign beat_o = beat_q;
endmodule

// File: rtl/spectral_flux.sv
// spectral_flux: half-wave rectified per-frame spectral flux with band split and onset flag.
//   clk, reset : clock, synchronous active-high reset
//   bus        : spectral_flux_if.slave (mag_valid/mag_sq in; flux_value, flux_low/mid/high,
//                flux_accum, flux_valid, beat_valid, frame_done out)
module spectral_flux
   import spectral_flux_pkg::*;
#(
   parameter int W = spectral_flux_pkg::W,
   parameter int N = spectral_flux_pkg::N
) (
   input logic             clk,
   input logic             reset,
   spectral_flux_if.slave  bus
);
   localparam int BW = $clog2(N);

   logic [BW-1:0] cnt_q, cnt_d;
   logic [W-1:0]  prev_q [N];
   flux_t         acc_q, acc_d, low_q, low_d, mid_q, mid_d, high_q, high_d;
   flux_t         fval_q, flow_q, fmid_q, fhigh_q;
   logic          fvalid_q;
   flux_t         d, tot, lo, mi, hi;
   logic          last;

   // tot/lo/mi/hi are the sums including the current bin; at frame end they go
   // straight to the outputs while the accumulators restart at zero, so a bin
   // arriving in the very next cycle starts the new frame cleanly.
   always_comb begin
      d      = (bus.mag_sq > prev_q[cnt_q]) ? flux_t'(bus.mag_sq - prev_q[cnt_q]) : '0;
      last   = bus.mag_valid && (cnt_q == BW'(N - 1));
      tot    = sat_add(acc_q, d);
      lo     = (cnt_q < BW'(N / 4)) ? sat_add(low_q, d) : low_q;
      mi     = (cnt_q >= BW'(N / 4) && cnt_q < BW'(N / 2)) ? sat_add(mid_q, d) : mid_q;
      hi     = (cnt_q >= BW'(N / 2)) ? sat_add(high_q, d) : high_q;
      cnt_d  = cnt_q + BW'(bus.mag_valid);
      acc_d  = !bus.mag_valid ? acc_q  : last ? '0 : tot;
      low_d  = !bus.mag_valid ? low_q  : last ? '0 : lo;
      mid_d  = !bus.mag_valid ? mid_q  : last ? '0 : mi;
      high_d = !bus.mag_valid ? high_q : last ? '0 : hi;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q    <= '0;
         prev_q   <= '{default: '0};
         acc_q    <= '0;
         low_q    <= '0;
         mid_q    <= '0;
         high_q   <= '0;
         fval_q   <= '0;
         flow_q   <= '0;
         fmid_q   <= '0;
         fhigh_q  <= '0;
         fvalid_q <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         low_q    <= low_d;
         mid_q    <= mid_d;
         high_q   <= high_d;
         fvalid_q <= last;
         if (bus.mag_valid) prev_q[cnt_q] <= bus.mag_sq;
         if (last) begin
            fval_q  <= tot;
            flow_q  <= lo;
            fmid_q  <= mi;
            fhigh_q <= hi;
         end
      end
   end

   flux_beat_detector u_beat (
      .clk      (clk),
      .reset    (reset),
      .flux_i   (tot),
      .strobe_i (last),
      .beat_o   (bus.beat_valid)
   );

   assign bus.flux_value = fval_q;
   assign bus.flux_low   = flow_q;
   assign bus.flux_mid   = fmid_q;
   assign bus.flux_high  = fhigh_q;
   assign bus.flux_accum = acc_q;
   assign bus.flux_valid = fvalid_q;
   assign bus.frame_done = fvalid_q;
endmodule

// File: tb/tb_spectral_flux.sv
// tb_spectral_flux: directed and random frames checked against a per-frame reference model.
module tb_spectral_flux;
   typedef struct {
      longint tot;
      longint lo;
      longint mi;
      longint hi;
      bit     beat;
   } exp_t;

   logic   clk = 1'b0;
   logic   reset = 1'b1;
   int     checks = 0;
   int     errors = 0;
   int     pulses = 0;
   int     pushed = 0;
   exp_t   exp_q[$];
   longint prev_m[8];
   longint avg_m;

   spectral_flux_if #(.W(16)) bus ();

   spectral_flux dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(string tag, longint obs, longint exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic longint sat(longint v);
      return (v > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : v;
   endfunction

   always @(negedge clk) begin
      if (!reset) begin
         check("frame_done_eq_valid", bus.frame_done, bus.flux_valid);
         if (bus.flux_valid) begin
            pulses++;
            if (exp_q.size() == 0) begin
               check("unexpected_pulse", 1, 0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("flux_value", bus.flux_value, e.tot);
               check("flux_low", bus.flux_low, e.lo);
               check("flux_mid", bus.flux_mid, e.mi);
               check("flux_high", bus.flux_high, e.hi);
               check("beat_valid", bus.beat_valid, e.beat);
            end
         end else begin
            check("beat_outside_pulse", bus.beat_valid, 0);
         end
      end
   end

   task automatic model_reset();
      foreach (prev_m[i]) prev_m[i] = 0;
      avg_m = 0;
      exp_q.delete();
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      bus.mag_valid = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask

   task automatic idle(int n);
      repeat (n) begin
         @(negedge clk);
         bus.mag_valid = 1'b0;
      end
   endtask

   // Whole-frame model: rectified differences against the previous frame,
   // band split by bin index, beat against 1.5x the pre-update average.
   task automatic frame(input int vals[8], input bit gaps);
      exp_t   e;
      longint dd[8];
      longint part;
      e = '{0, 0, 0, 0, 0};
      for (int i = 0; i < 8; i++) begin
         dd[i] = (vals[i] > prev_m[i]) ? vals[i] - prev_m[i] : 0;
         prev_m[i] = vals[i];
         e.tot = sat(e.tot + dd[i]);
         if (i < 2) e.lo = sat(e.lo + dd[i]);
         else if (i < 4) e.mi = sat(e.mi + dd[i]);
         else e.hi = sat(e.hi + dd[i]);
      end
      e.beat = (e.tot != 0) && (e.tot > avg_m + avg_m / 2);
      avg_m = (avg_m - avg_m / 8 + e.tot / 8) & 64'hFFFF_FFFF;
      exp_q.push_back(e);
      pushed++;
      part = 0;
      for (int i = 0; i < 8; i++) begin
         repeat (gaps ? $urandom_range(0, 2) : 0) begin
            @(negedge clk);
            bus.mag_valid = 1'b0;
            check("accum_gap", bus.flux_accum, part);
         end
         @(negedge clk);
         check("accum", bus.flux_accum, part);
         bus.mag_valid = 1'b1;
         bus.mag_sq = 16'(vals[i]);
         part += dd[i];
      end
   endtask

   initial begin
      int flat[8];
      int ramp[8];
      int mix[8];
      int r[8];
      bus.mag_valid = 1'b0;
      bus.mag_sq = '0;
      model_reset();
      do_reset();
      check("rst_flux_value", bus.flux_value, 0);
      check("rst_flux_accum", bus.flux_accum, 0);
      check("rst_flux_valid", bus.flux_valid, 0);
      check("rst_beat_valid", bus.beat_valid, 0);
      check("rst_bands", bus.flux_low | bus.flux_mid | bus.flux_high, 0);

      flat = '{200, 200, 200, 200, 200, 200, 200, 200};
      mix  = '{100, 700, 1400, 100, 700, 1400, 100, 700};
      for (int i = 0; i < 8; i++) ramp[i] = 100 + 20 * i;

      frame(flat, 0);
      idle(2);
      check("f1_value_hold", bus.flux_value, 1600);
      check("f1_high_hold", bus.flux_high, 800);
      check("f1_valid_low", bus.flux_valid, 0);

      frame(ramp, 0);
      frame(mix, 0);
      idle(2);
      check("f3_value", bus.flux_value, 4020);
      check("f3_low", bus.flux_low, 580);
      check("f3_mid", bus.flux_mid, 1260);
      check("f3_high", bus.flux_high, 2180);

      for (int i = 0; i < 8; i++) r[i] = $urandom_range(0, 65535);
      frame(r, 0);
      frame(r, 0);
      idle(2);
      check("repeat_zero", bus.flux_value, 0);

      frame(mix, 1);
      idle(1);
      frame(ramp, 1);
      idle(2);

      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         bus.mag_valid = 1'b1;
         bus.mag_sq = 16'd5000;
      end
      do_reset();
      check("partial_accum_cleared", bus.flux_accum, 0);
      frame(flat, 0);
      idle(2);
      check("after_reset_value", bus.flux_value, 1600);

      for (int f = 0; f < 12; f++) begin
         for (int i = 0; i < 8; i++)
            r[i] = (f % 3 == 0) ? $urandom_range(0, 65535) : $urandom_range(0, 3000);
         frame(r, 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
      end
      idle(3);
      check("pending_expected", exp_q.size(), 0);
      check("pulse_count", pulses, pushed);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
